// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-back, write-allocate cache controller with one 32-bit word per line.
// Handles one CPU request at a time and drives the memory port through a four-state FSM.
module cache_ctrl_dm #(
    parameter int TAGMSB = 31,
    parameter int TAGLSB = 7,
    parameter int INDEX  = 5,
    parameter int DEPTH  = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] cpu_req_addr,
    input  logic [31:0] cpu_req_data,
    input  logic        cpu_req_rw,
    input  logic        cpu_req_valid,
    output logic [31:0] cpu_res_data,
    output logic        cpu_res_ready,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic        mem_req_rw,
    output logic        mem_req_valid,
    input  logic [31:0] mem_data,
    input  logic        mem_ready
);

    localparam int TW = TAGMSB - TAGLSB + 1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        COMPARE_TAG = 2'd1,
        WRITE_BACK  = 2'd2,
        ALLOCATE    = 2'd3
    } state_t;

    state_t                   state_r;
    logic [TAGMSB:TAGLSB-INDEX] addr_r;
    logic [31:0]              wdata_r;
    logic                     rw_r;
    logic [DEPTH-1:0]         valid_r;
    logic [DEPTH-1:0]         dirty_r;
    logic [TW-1:0]            tag_mem_r  [DEPTH];
    logic [31:0]              data_mem_r [DEPTH];

    logic [INDEX-1:0] idx_s;
    logic [TW-1:0]    tag_s;
    logic [TW-1:0]    vic_tag_s;
    logic [31:0]      vic_data_s;
    logic             hit_s;
    logic             vic_dirty_s;
    logic [31:0]      wb_addr_s;
    logic [31:0]      alloc_addr_s;
    logic             fill_s;
    logic             write_hit_s;
    logic             line_we_s;
    logic [31:0]      line_wdata_s;

    // Lookup of the line addressed by the latched request, plus line-update controls.
    always_comb begin
        idx_s        = addr_r[TAGLSB-1:TAGLSB-INDEX];
        tag_s        = addr_r[TAGMSB:TAGLSB];
        vic_tag_s    = tag_mem_r[idx_s];
        vic_data_s   = data_mem_r[idx_s];
        hit_s        = valid_r[idx_s] && (vic_tag_s == tag_s);
        vic_dirty_s  = valid_r[idx_s] && dirty_r[idx_s];
        wb_addr_s    = {vic_tag_s, idx_s, 2'b00};
        alloc_addr_s = {tag_s, idx_s, 2'b00};
        fill_s       = (state_r == ALLOCATE) && mem_ready;
        write_hit_s  = (state_r == COMPARE_TAG) && hit_s && rw_r;
        line_we_s    = fill_s || write_hit_s;
        if (fill_s) begin
            line_wdata_s = mem_data;
        end else begin
            line_wdata_s = wdata_r;
        end
    end

    // Tag and data storage; only valid/dirty are cleared by reset.
    always_ff @(posedge clk_i) begin
        if (line_we_s) begin
            data_mem_r[idx_s] <= line_wdata_s;
            tag_mem_r[idx_s]  <= tag_s;
        end
    end

    // Controller FSM with registered CPU and memory outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= IDLE;
            addr_r        <= '0;
            wdata_r       <= 32'h0;
            rw_r          <= 1'b0;
            valid_r       <= '0;
            dirty_r       <= '0;
            cpu_res_data  <= 32'h0;
            cpu_res_ready <= 1'b0;
            mem_req_addr  <= 32'h0;
            mem_req_data  <= 32'h0;
            mem_req_rw    <= 1'b0;
            mem_req_valid <= 1'b0;
        end else begin
            cpu_res_ready <= 1'b0;
            cpu_res_data  <= 32'h0;
            case (state_r)
                IDLE: begin
                    if (cpu_req_valid) begin
                        addr_r  <= cpu_req_addr[TAGMSB:TAGLSB-INDEX];
                        wdata_r <= cpu_req_data;
                        rw_r    <= cpu_req_rw;
                        state_r <= COMPARE_TAG;
                    end
                end
                COMPARE_TAG: begin
                    if (hit_s) begin
                        cpu_res_ready <= 1'b1;
                        if (rw_r) begin
                            dirty_r[idx_s] <= 1'b1;
                        end else begin
                            cpu_res_data <= vic_data_s;
                        end
                        state_r <= IDLE;
                    end else if (vic_dirty_s) begin
                        mem_req_valid <= 1'b1;
                        mem_req_rw    <= 1'b1;
                        mem_req_addr  <= wb_addr_s;
                        mem_req_data  <= vic_data_s;
                        state_r       <= WRITE_BACK;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_rw    <= 1'b0;
                        mem_req_addr  <= alloc_addr_s;
                        mem_req_data  <= 32'h0;
                        state_r       <= ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (mem_ready) begin
                        mem_req_rw   <= 1'b0;
                        mem_req_addr <= alloc_addr_s;
                        mem_req_data <= 32'h0;
                        state_r      <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    // The refilled line is re-examined in COMPARE_TAG, where it now hits.
                    if (mem_ready) begin
                        valid_r[idx_s] <= 1'b1;
                        dirty_r[idx_s] <= 1'b0;
                        mem_req_valid  <= 1'b0;
                        mem_req_rw     <= 1'b0;
                        mem_req_addr   <= 32'h0;
                        mem_req_data   <= 32'h0;
                        state_r        <= COMPARE_TAG;
                    end
                end
                default: begin
                    mem_req_valid <= 1'b0;
                    mem_req_rw    <= 1'b0;
                    mem_req_addr  <= 32'h0;
                    mem_req_data  <= 32'h0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

endmodule
